// File: rtl/usb_audio_pkg.sv
// Shared types and defaults for the USB audio sample pacer.
package usb_audio_pkg;

  // 60 MHz core clock divided down to the 48 kHz output sample rate
  localparam int CLK_DIV_DEFAULT = 1250;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PLAY = 2'd2
  } pacer_state_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } stereo_t;

  // Event counters stick at 255 rather than wrapping back to a small value
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_audio_fifo.sv
// Single-clock stereo sample FIFO. Read data is registered: it appears in
// the cycle after an accepted pop and holds until the next pop or rd_zero.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module usb_audio_fifo
  import usb_audio_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          push,
  input  stereo_t       wr_data,
  input  logic          pop,
  input  logic          rd_zero,
  output stereo_t       rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  stereo_t       mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign pop_ok  = pop && !flush && !empty;
  assign push_ok = push && !flush && (!full || pop_ok);

  // Sample storage; left without reset so it can map onto a RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy, cleared together on flush
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (pop_ok && !push_ok) begin
        level <= level - 1'b1;
      end
    end
  end

  // Read register doubles as the DAC output register; rd_zero mutes it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (rd_zero) begin
      rd_data <= '0;
    end else if (pop_ok) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/usb_audio_sample_pacer.sv
// Buffers bursty USB isochronous stereo samples and releases one per
// 48 kHz tick to the DAC, muting while the buffer refills.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | streaming off: FIFO flushed every cycle, inputs ignored, mute
//   FILL  | collecting samples, muted ticks until level reaches PREFILL
//   PLAY  | one sample popped per tick; empty FIFO on a tick -> underrun
module usb_audio_sample_pacer
  import usb_audio_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int FIFO_AW = 7,
  parameter int PREFILL = 64
) (
  input  logic               rstn,
  input  logic               clk,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [15:0]        in_l,
  input  logic [15:0]        in_r,
  output logic [15:0]        audio_L_ch,
  output logic [15:0]        audio_R_ch,
  output logic               sample_tick,
  output logic               playing,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         underrun_cnt,
  output logic [7:0]         overflow_cnt
);

  localparam int                 CNT_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0]   TC          = CNT_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   PREFILL_LVL = (FIFO_AW + 1)'(PREFILL);

  pacer_state_t     state;
  pacer_state_t     state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  stereo_t          in_sample;
  stereo_t          rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fill_ready;

  logic             push_req;
  logic             pop_req;
  logic             flush;
  logic             rd_zero;
  logic             underrun_evt;
  logic             overflow_evt;

  assign in_sample  = '{l: in_l, r: in_r};
  assign fill_ready = (fifo_level >= PREFILL_LVL);
  assign tick       = enable && (tick_cnt == TC);

  // Sample-rate divider: free-running while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
    end else if (!enable || (tick_cnt == TC)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision; dropping enable always returns to IDLE
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = FILL;
        FILL:    if (tick && fill_ready) state_next = PLAY;
        PLAY:    if (tick && fifo_empty) state_next = FILL;
        default: state_next = IDLE;
      endcase
    end
  end

  // FIFO control and per-tick actions for the current state
  always_comb begin
    pop_req      = 1'b0;
    rd_zero      = 1'b0;
    underrun_evt = 1'b0;
    push_req     = enable && in_valid && (state != IDLE);
    flush        = !enable || (state == IDLE);
    if (flush) begin
      rd_zero = 1'b1;
    end else begin
      case (state)
        FILL: begin
          if (tick) begin
            if (fill_ready) begin
              pop_req = 1'b1;
            end else begin
              rd_zero = 1'b1;
            end
          end
        end
        PLAY: begin
          if (tick) begin
            if (!fifo_empty) begin
              pop_req = 1'b1;
            end else begin
              rd_zero      = 1'b1;
              underrun_evt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A full FIFO only drops the sample when no pop frees a slot this cycle
  assign overflow_evt = push_req && fifo_full && !pop_req;

  // Registered status outputs and sticky event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_tick  <= 1'b0;
      playing      <= 1'b0;
      underrun_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      sample_tick <= tick;
      playing     <= (state_next == PLAY);
      if (underrun_evt) begin
        underrun_cnt <= sat_inc8(underrun_cnt);
      end
      if (overflow_evt) begin
        overflow_cnt <= sat_inc8(overflow_cnt);
      end
    end
  end

  usb_audio_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (flush),
    .push    (push_req),
    .wr_data (in_sample),
    .pop     (pop_req),
    .rd_zero (rd_zero),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign audio_L_ch = rd_data.l;
  assign audio_R_ch = rd_data.r;

endmodule

// File: tb/tb_usb_audio_sample_pacer.sv
// Scoreboard bench for usb_audio_sample_pacer. Accepted pushes go into a
// reference queue; every observed sample_tick pops the expected sample (or
// expects silence) from a behavioural prefill/play/underrun model.
module tb_usb_audio_sample_pacer;

  localparam int CLK_DIV = 160;
  localparam int FIFO_AW = 7;
  localparam int PREFILL = 64;
  localparam int DEPTH   = 1 << FIFO_AW;

  logic             rstn;
  logic             clk;
  logic             enable;
  logic             in_valid;
  logic [15:0]      in_l;
  logic [15:0]      in_r;
  logic [15:0]      audio_L_ch;
  logic [15:0]      audio_R_ch;
  logic             sample_tick;
  logic             playing;
  logic [FIFO_AW:0] fifo_level;
  logic [7:0]       underrun_cnt;
  logic [7:0]       overflow_cnt;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          last_tick_cyc;
  bit          gap_valid;
  bit          m_play;
  int          m_under;
  int          m_ovf;
  logic [31:0] exp_q[$];

  usb_audio_sample_pacer #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (FIFO_AW),
    .PREFILL (PREFILL)
  ) dut (
    .rstn         (rstn),
    .clk          (clk),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_l         (in_l),
    .in_r         (in_r),
    .audio_L_ch   (audio_L_ch),
    .audio_R_ch   (audio_R_ch),
    .sample_tick  (sample_tick),
    .playing      (playing),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .overflow_cnt (overflow_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: one model step per observed output tick
  always @(negedge clk) begin : mon
    logic [31:0] exp_v;
    if (rstn && sample_tick) begin
      if (gap_valid) check_eq("tick_gap", cyc - last_tick_cyc, CLK_DIV);
      last_tick_cyc = cyc;
      gap_valid     = 1'b1;
      if (m_play) begin
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
        end else begin
          exp_v  = '0;
          m_play = 1'b0;
          if (m_under < 255) m_under++;
        end
      end else if (exp_q.size() >= PREFILL) begin
        exp_v  = exp_q.pop_front();
        m_play = 1'b1;
      end else begin
        exp_v = '0;
      end
      check_eq("audio_l", audio_L_ch, exp_v[31:16]);
      check_eq("audio_r", audio_R_ch, exp_v[15:0]);
      check_eq("playing", playing, m_play);
      check_eq("underrun_cnt", underrun_cnt, m_under);
    end
  end

  task automatic wait_tick();
    int budget;
    budget = 2 * CLK_DIV;
    do begin
      @(negedge clk);
      budget--;
    end while (!sample_tick && budget > 0);
    check_eq("tick_seen", sample_tick, 1);
  endtask

  task automatic drive_sample(input int v);
    in_valid = 1'b1;
    in_l     = 16'(v);
    in_r     = 16'(v + 16'h4000);
  endtask

  task automatic push_burst(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_sample(base + i);
      if (exp_q.size() < DEPTH) exp_q.push_back({in_l, in_r});
      else m_ovf++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_stream();
    @(negedge clk);
    enable        = 1'b1;
    last_tick_cyc = cyc;
    gap_valid     = 1'b1;
  endtask

  initial begin
    int seen;
    rstn = 1'b0; enable = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_audio_l", audio_L_ch, 0);
    check_eq("rst_audio_r", audio_R_ch, 0);
    check_eq("rst_tick", sample_tick, 0);
    check_eq("rst_playing", playing, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_underrun", underrun_cnt, 0);
    check_eq("rst_overflow", overflow_cnt, 0);
    rstn = 1'b1;

    // Prefill: 63 samples stay muted, the 64th starts playback
    start_stream();
    push_burst(1, 63);
    repeat (3) wait_tick();
    check_eq("fill_playing", playing, 0);
    check_eq("fill_level", fifo_level, 63);
    push_burst(64, 1);
    wait_tick();
    check_eq("play_first_l", audio_L_ch, 16'h0001);
    check_eq("play_first_p", playing, 1);

    // Underrun after the 64 queued samples drain
    repeat (64) wait_tick();
    check_eq("under_cnt_a", underrun_cnt, 1);
    check_eq("under_playing", playing, 0);
    check_eq("under_audio", audio_L_ch, 0);

    // Resume and steady stream of 48-sample frames
    push_burst(1000, 64);
    wait_tick();
    check_eq("resume_l", audio_L_ch, 1000);
    for (int f = 0; f < 2; f++) begin
      repeat (48) wait_tick();
      push_burst(1100 + f * 48, 48);
    end
    repeat (5) wait_tick();
    check_eq("steady_under", underrun_cnt, 1);
    check_eq("steady_ovf", overflow_cnt, 0);
    check_eq("steady_playing", playing, 1);

    // Disable mid-play
    repeat (5) @(negedge clk);
    enable    = 1'b0;
    gap_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    m_play = 1'b0;
    check_eq("dis_level", fifo_level, 0);
    check_eq("dis_audio_l", audio_L_ch, 0);
    check_eq("dis_audio_r", audio_R_ch, 0);
    check_eq("dis_tick", sample_tick, 0);
    check_eq("dis_playing", playing, 0);
    check_eq("dis_under_kept", underrun_cnt, 1);
    seen = 0;
    repeat (2 * CLK_DIV) begin
      @(negedge clk);
      if (sample_tick) seen++;
    end
    check_eq("dis_no_tick", seen, 0);

    // Overflow: 130 back-to-back pushes before the first tick
    start_stream();
    push_burst(2000, 130);
    check_eq("ovf_level", fifo_level, DEPTH);
    check_eq("ovf_cnt", overflow_cnt, m_ovf);
    check_eq("ovf_cnt_2", overflow_cnt, 2);
    wait_tick();
    check_eq("ovf_first_l", audio_L_ch, 2000);

    // Refill to full, then push coincident with a tick pop
    @(negedge clk);
    drive_sample(5000);
    exp_q.push_back({in_l, in_r});
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("full_level", fifo_level, DEPTH);
    repeat (CLK_DIV - 3) @(negedge clk);
    drive_sample(6000);
    exp_q.push_back({in_l, in_r});
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pp_tick", sample_tick, 1);
    check_eq("pp_level", fifo_level, DEPTH);
    check_eq("pp_ovf", overflow_cnt, 2);

    // Drain all retained samples, including the two late pushes
    repeat (129) wait_tick();
    check_eq("under_cnt_b", underrun_cnt, 2);
    check_eq("under_b_play", playing, 0);

    // Resume, then asynchronous reset mid-cycle
    push_burst(3000, 64);
    repeat (3) wait_tick();
    check_eq("pre_rst_l", audio_L_ch, 3002);
    repeat (7) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check_eq("arst_audio_l", audio_L_ch, 0);
    check_eq("arst_audio_r", audio_R_ch, 0);
    check_eq("arst_playing", playing, 0);
    check_eq("arst_level", fifo_level, 0);
    check_eq("arst_under", underrun_cnt, 0);
    check_eq("arst_ovf", overflow_cnt, 0);
    check_eq("arst_tick", sample_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_audio_sample_pacer.md
Name: usb_audio_sample_pacer

Overview:
- Sits between the USB audio class core's host-to-device sample output and the 16-bit L/R DAC ports.
- USB delivers stereo samples in bursts, about 48 per 1 ms isochronous frame.
- This block buffers them in a FIFO and releases exactly one stereo sample per 48 kHz tick derived from clk.
- A prefill/play/underrun state machine mutes the output to zero while the buffer is refilling.

Parameters:
- CLK_DIV, 1250: clk cycles per output sample (60 MHz / 48 kHz).
- FIFO_AW, 7: FIFO address width; depth = 2**FIFO_AW = 128 stereo samples.
- PREFILL, 64: FIFO level required before playback (re)starts; legal range 1..2**FIFO_AW.

Ports:
- rstn  input  1  asynchronous active-low reset
- clk  input  1  core clock, 60 MHz
- enable  input  1  1 = streaming active (alt setting != 0); 0 = flush and mute
- in_valid  input  1  one-cycle strobe: in_l/in_r hold a new stereo sample
- in_l  input  16  left sample, two's complement
- in_r  input  16  right sample, two's complement
- audio_L_ch  output  16  registered left DAC sample
- audio_R_ch  output  16  registered right DAC sample
- sample_tick  output  1  one-cycle pulse, asserted in the cycle audio_*_ch updates
- playing  output  1  1 while in state PLAY
- fifo_level  output  FIFO_AW+1  current FIFO occupancy
- underrun_cnt  output  8  saturating count of underrun events
- overflow_cnt  output  8  saturating count of dropped input samples

Behaviour:
- Reset: all outputs 0; state IDLE; FIFO empty; tick counter 0. Reset may assert at any cycle and takes effect immediately.
- Tick counter:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - An internal tick fires in the cycle the counter equals CLK_DIV-1.
  - It runs continuously whenever enable=1.
  - It is held at 0 while enable=0.
- FIFO push:
  - in_valid=1 with FIFO not full: {in_l,in_r} is written.
  - in_valid=1 with FIFO full and no pop in the same cycle: the sample is dropped and overflow_cnt increments, saturating at 255.
  - Push and pop in the same cycle with FIFO full: both are accepted and the level is unchanged.
  - No backpressure exists (isochronous source).
- States: IDLE, FILL, PLAY.
  - IDLE: entered on reset or enable=0. FIFO is flushed every cycle, in_valid is ignored, outputs are 0. Moves to FILL in the cycle after enable=1 is seen.
  - FILL: pushes are accepted, nothing is popped, audio_*_ch = 0. On a tick with fifo_level >= PREFILL, the sample is popped and the state goes to PLAY.
  - PLAY: on each tick, if the FIFO is non-empty the sample is popped. If it is empty, underrun_cnt increments (saturating), audio_*_ch are set to 0, and the state goes to FILL.
- Output timing:
  - A pop on tick cycle T drives audio_L_ch/audio_R_ch and sample_tick=1 in cycle T+1.
  - sample_tick also pulses at T+1 for muted (zero) updates in FILL and on underrun, so the DAC sees a steady 48 kHz cadence whenever enable=1.
  - Between ticks, outputs hold their value.
- enable falling:
  - The next cycle: state IDLE, FIFO flushed, audio_*_ch = 0, sample_tick = 0, tick counter = 0.
  - Counters underrun_cnt and overflow_cnt are preserved; only rstn clears them.
- fifo_level: registered and updated the same cycle as the push/pop pointer update; range 0..2**FIFO_AW.
- playing = (state == PLAY), registered.

Decomposition:
- Package usb_audio_pkg: state enum (IDLE, FILL, PLAY), typedef for the stereo sample struct {l[15:0], r[15:0]}, and the default CLK_DIV constant.
- Sub-module usb_audio_fifo: synchronous single-clock FIFO, 32-bit wide, depth 2**FIFO_AW, with push/pop/flush, full/empty and level.
  - Write-during-full-and-pop is allowed.
  - Read data is valid in the cycle after pop.

Test Plan:
- Prefill: enable=1, push 63 samples (value n in both channels), wait 3 ticks -> outputs stay 0 with sample_tick every 1250 cycles and playing=0. Push the 64th sample -> at the next tick, outputs = 0x0001 one cycle later and playing=1.
- Steady stream: push 48 samples every 60000 cycles -> samples emerge in order, exactly one every 1250 cycles; underrun_cnt and overflow_cnt stay 0.
- Underrun: after PLAY starts with 64 queued and no further pushes -> 64 samples play, then at the next tick outputs = 0, underrun_cnt = 1, playing = 0. Push 64 more -> playback resumes.
- Overflow: enable=1, push 130 samples back-to-back with no tick -> fifo_level = 128, overflow_cnt = 2, the first 128 values are retained.
- Full push+pop: FIFO full, in_valid coincident with a tick pop -> sample accepted, fifo_level stays 128, overflow_cnt unchanged.
- Disable/reset mid-play: drop enable during PLAY -> next cycle fifo_level = 0, outputs = 0, counters kept. Then assert rstn=0 asynchronously mid-cycle -> all outputs 0 immediately, counters cleared.
